dual_port_ram_ctrl: RTL and testbench

//  Parametrised two-port word RAM: read-only instruction port (I) and read/write data port (D).

---
 rtl/dual_port_ram_ctrl_if.sv | 51 +++++
 rtl/dual_port_ram_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dual_port_ram_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_ctrl_if
// Groups the instruction-port and data-port request/response signals of the
// dual-port RAM controller into one bundle.
//
//   ready                      RAM -> core  requests are accepted when 1
//   i_req, i_addr              core -> RAM  instruction read request
//   i_valid, i_data, i_err     RAM -> core  instruction read response
//   d_req, d_we, d_be,
//   d_addr, d_wdata            core -> RAM  data read/write request
//   d_valid, d_rdata, d_err    RAM -> core  data response
//
// Modports: master = core side (fetch/LSU), slave = RAM controller side.
// -----------------------------------------------------------------------------
interface dual_port_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      ready;

    logic                      i_req;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic                      i_valid;
    logic [DATA_WIDTH-1:0]     i_data;
    logic                      i_err;

    logic                      d_req;
    logic                      d_we;
    logic [DATA_WIDTH/8-1:0]   d_be;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic                      d_valid;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_err;

    modport master (
        input  ready,
        output i_req, i_addr,
        input  i_valid, i_data, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_valid, d_rdata, d_err
    );

    modport slave (
        output ready,
        input  i_req, i_addr,
        output i_valid, i_data, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_valid, d_rdata, d_err
    );
endinterface

// File: rtl/dual_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// dual_port_ram_ctrl
// Two-port word RAM: read-only instruction port (I) and read/write data port
// (D). Byte-enable writes, registered one-cycle responses with valid strobes,
// same-cycle D-write -> I-read forwarding, address range checking and an
// optional zero-clear sweep after reset.
//
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset (memory contents are not reset)
//   bus      dual_port_ram_ctrl_if.slave: ready, I port (i_req/i_addr ->
//            i_valid/i_data/i_err), D port (d_req/d_we/d_be/d_addr/d_wdata
//            -> d_valid/d_rdata/d_err)
// The interface instance must use the same DATA_WIDTH/ADDR_WIDTH.
// -----------------------------------------------------------------------------
module dual_port_ram_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    dual_port_ram_ctrl_if.slave    bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, next_state;
    logic                  clr_we;
    logic [IDX_W-1:0]      clr_cnt;
    logic                  ready_p1;

    logic                  i_acc, d_acc;
    logic                  i_ok, d_ok;
    logic [IDX_W-1:0]      i_idx, d_idx;
    logic [DATA_WIDTH-1:0] d_old, d_merged, d_word, i_word;
    logic                  d_wr, i_fwd;

    logic                  i_vld_p1, i_err_p1;
    logic [DATA_WIDTH-1:0] i_data_p1;
    logic                  d_vld_p1, d_err_p1;
    logic [DATA_WIDTH-1:0] d_data_p1;

    // ---- request decode (combinational, accept stage) ----
    assign i_acc    = bus.i_req & ready_p1;
    assign d_acc    = bus.d_req & ready_p1;
    assign i_ok     = in_range(bus.i_addr);
    assign d_ok     = in_range(bus.d_addr);
    assign i_idx    = bus.i_addr[IDX_W-1:0];
    assign d_idx    = bus.d_addr[IDX_W-1:0];

    assign d_old    = mem[d_idx];
    assign d_merged = merge_bytes(d_old, bus.d_wdata, bus.d_be);
    assign d_wr     = d_acc & bus.d_we & d_ok;
    // I port sees the word as it will be after this cycle's D write.
    assign i_fwd    = d_wr & i_ok & (bus.i_addr == bus.d_addr);
    assign i_word   = i_fwd ? d_merged : mem[i_idx];
    assign d_word   = bus.d_we ? d_merged : d_old;

    // ---- clear-sweep FSM ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt  <= '0;
            ready_p1 <= 1'b0;
        end else begin
            state    <= next_state;
            ready_p1 <= (next_state == ST_RUN);
            if (clr_we) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        clr_we     = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_IDX) next_state = ST_RUN;
            end
            ST_RUN: begin
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_CLEAR;
            end
        endcase
    end

    // ---- storage write ----
    // No requests are accepted while clearing, so the two writers never collide.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (d_wr) begin
            mem[d_idx] <= d_merged;
        end
    end

    // ---- response stage (p1) ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_vld_p1  <= 1'b0;
            i_err_p1  <= 1'b0;
            i_data_p1 <= '0;
        end else if (i_acc) begin
            i_vld_p1  <= 1'b1;
            i_err_p1  <= ~i_ok;
            i_data_p1 <= i_ok ? i_word : '0;
        end else begin
            i_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_vld_p1  <= 1'b0;
            d_err_p1  <= 1'b0;
            d_data_p1 <= '0;
        end else if (d_acc) begin
            d_vld_p1  <= 1'b1;
            d_err_p1  <= ~d_ok;
            d_data_p1 <= d_ok ? d_word : '0;
        end else begin
            d_vld_p1  <= 1'b0;
        end
    end

    assign bus.ready   = ready_p1;
    assign bus.i_valid = i_vld_p1;
    assign bus.i_data  = i_data_p1;
    assign bus.i_err   = i_err_p1;
    assign bus.d_valid = d_vld_p1;
    assign bus.d_rdata = d_data_p1;
    assign bus.d_err   = d_err_p1;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_ctrl
// Bench for dual_port_ram_ctrl with DEPTH=16, 32-bit words, 8-bit addresses.
// Table rows carry request fields plus the expected response; the driver
// pushes expectations into per-port queues and a negedge monitor pops and
// compares them when the valid strobes appear.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    dual_port_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEPTH         (DEPTH),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;

    typedef struct {
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [3:0]    be;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_i;
        logic          exp_ierr;
        logic [DW-1:0] exp_d;
        logic          exp_derr;
    } vec_t;

    exp_t iq[$];
    exp_t dq[$];
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---- scoreboard monitor ----
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (bus.i_valid) begin
                if (iq.size() == 0) begin
                    check("i_unexpected_valid", 32'(bus.i_valid), 32'd0);
                end else begin
                    e = iq.pop_front();
                    check("i_latency", 32'(cyc), 32'(e.due));
                    check("i_data", bus.i_data, e.data);
                    check("i_err", 32'(bus.i_err), 32'(e.err));
                end
            end else if (iq.size() > 0 && iq[0].due <= cyc) begin
                check("i_missing_valid", 32'(bus.i_valid), 32'd1);
                e = iq.pop_front();
            end
            if (bus.d_valid) begin
                if (dq.size() == 0) begin
                    check("d_unexpected_valid", 32'(bus.d_valid), 32'd0);
                end else begin
                    e = dq.pop_front();
                    check("d_latency", 32'(cyc), 32'(e.due));
                    check("d_rdata", bus.d_rdata, e.data);
                    check("d_err", 32'(bus.d_err), 32'(e.err));
                end
            end else if (dq.size() > 0 && dq[0].due <= cyc) begin
                check("d_missing_valid", 32'(bus.d_valid), 32'd1);
                e = dq.pop_front();
            end
        end
    end

    task automatic drive(input vec_t v);
        @(posedge clock);
        #1;
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_be    = v.be;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.wdata;
        if (v.i_req) iq.push_back('{v.exp_i, v.exp_ierr, cyc + 1});
        if (v.d_req) dq.push_back('{v.exp_d, v.exp_derr, cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
    endtask

    // Releases reset with requests held active, counts cycles until ready,
    // and checks that nothing is answered during the sweep.
    task automatic release_and_count(input string name);
        int n;
        n = 0;
        @(posedge clock);
        #1;
        reset_n     = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 8'd4;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'hF;
        bus.d_addr  = 8'd4;
        bus.d_wdata = 32'hFFFF_FFFF;
        while (n < 100) begin
            @(posedge clock);
            #1;
            n++;
            check("sweep_no_i_valid", 32'(bus.i_valid), 32'd0);
            if (bus.ready) break;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check(name, 32'(n), 32'(DEPTH));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   32'(bus.ready),   32'd0);
        check({tag, "_i_valid"}, 32'(bus.i_valid), 32'd0);
        check({tag, "_d_valid"}, 32'(bus.d_valid), 32'd0);
        check({tag, "_i_data"},  bus.i_data,       32'd0);
        check({tag, "_d_rdata"}, bus.d_rdata,      32'd0);
        check({tag, "_errs"},    32'({bus.i_err, bus.d_err}), 32'd0);
    endtask

    task automatic read_all_zero();
        vec_t v;
        for (int a = 0; a < DEPTH; a++) begin
            v = '{1'b1, AW'(a), 1'b1, 1'b0, 4'h0, AW'(DEPTH - 1 - a), 32'd0,
                  32'd0, 1'b0, 32'd0, 1'b0};
            drive(v);
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        //           i_req i_addr  d_req we  be     d_addr  wdata          exp_i          ierr exp_d          derr
        vecs.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 4'hF, 8'd3,   32'hDEADBEEF, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 4'h2, 8'd3,   32'h0000AA00, 32'h0,         1'b0, 32'hDEADAAEF, 1'b0});
        vecs.push_back('{1'b1, 8'd3,   1'b1, 1'b0, 4'h0, 8'd3,   32'h0,        32'hDEADAAEF,  1'b0, 32'hDEADAAEF, 1'b0});
        vecs.push_back('{1'b1, 8'd5,   1'b1, 1'b1, 4'hF, 8'd5,   32'h12345678, 32'h12345678,  1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 8'd16,  1'b1, 1'b1, 4'hF, 8'd23,  32'hCAFEF00D, 32'h0,         1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 8'd7,   1'b1, 1'b0, 4'h0, 8'd15,  32'h0,        32'h0,         1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 8'd255, 1'b1, 1'b0, 4'h0, 8'd16,  32'h0,        32'h0,         1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 8'd5,   1'b1, 1'b1, 4'h0, 8'd5,   32'hFFFFFFFF, 32'h12345678,  1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 8'd15,  1'b1, 1'b1, 4'h9, 8'd15,  32'hA1B2C3D4, 32'hA10000D4,  1'b0, 32'hA10000D4, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 4'hF, 8'd1,   32'h11111111, 32'h0,         1'b0, 32'h11111111, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 4'hF, 8'd2,   32'h22222222, 32'h0,         1'b0, 32'h22222222, 1'b0});
        vecs.push_back('{1'b1, 8'd0,   1'b1, 1'b0, 4'h0, 8'd5,   32'h0,        32'h0,         1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 8'd1,   1'b1, 1'b0, 4'h0, 8'd15,  32'h0,        32'h11111111,  1'b0, 32'hA10000D4, 1'b0});
        vecs.push_back('{1'b1, 8'd2,   1'b0, 1'b0, 4'h0, 8'd0,   32'h0,        32'h22222222,  1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 8'd3,   1'b1, 1'b1, 4'hC, 8'd4,   32'h55667788, 32'hDEADAAEF,  1'b0, 32'h55660000, 1'b0});

        // Power-on reset and clear sweep.
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("por");
        release_and_count("por_ready_cycles");

        mon_en = 1'b1;
        read_all_zero();

        for (int k = 0; k < vecs.size(); k++) drive(vecs[k]);
        idle(3);
        check("i_queue_drained", 32'(iq.size()), 32'd0);
        check("d_queue_drained", 32'(dq.size()), 32'd0);

        // Reset while a read response is being presented.
        mon_en = 1'b0;
        iq.delete();
        dq.delete();
        @(posedge clock);
        #1;
        bus.i_req  = 1'b1;
        bus.i_addr = 8'd5;
        @(posedge clock);
        #1;
        bus.i_req = 1'b0;
        check("midread_i_valid", 32'(bus.i_valid), 32'd1);
        check("midread_i_data", bus.i_data, 32'h12345678);
        reset_n = 1'b0;
        #1;
        check_reset_values("midread_rst");

        // Reset in the middle of the clear sweep.
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        bus.i_req = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            check("midsweep_no_i_valid", 32'(bus.i_valid), 32'd0);
        end
        reset_n = 1'b0;
        #1;
        check_reset_values("midsweep_rst");
        bus.i_req = 1'b0;
        repeat (2) @(posedge clock);
        release_and_count("resweep_ready_cycles");

        mon_en = 1'b1;
        read_all_zero();
        check("final_i_queue_drained", 32'(iq.size()), 32'd0);
        check("final_d_queue_drained", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
